// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction ROM port, decode-side valid/ready stream
// and the execute redirect. master = fetch unit, slave = ROM/decode/execute side.
interface instr_fetch_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_folded;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_folded,
        input  imem_data, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_folded,
        output imem_data, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Nova instruction fetch: PC register, same-cycle ROM capture into a small FIFO,
// optional folding of unconditional J at fetch, and flush-on-redirect.
module instr_fetch #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2,
    parameter int FOLD_J   = 1
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q [DEPTH];
    logic [ADDR_W-1:0] epc_q   [DEPTH];
    logic              fold_q  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    logic head_valid, pop, push, fold;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count_q != '0);
    assign pop  = head_valid & bus.out_ready & ~bus.redirect_valid;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = ~bus.redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop);
    assign fold = (FOLD_J != 0) && (bus.imem_data[31:26] == 6'h28);
    assign pc_d = fold ? bus.imem_data[ADDR_W-1:0] : pc_q + 1'b1;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= ADDR_W'(RESET_PC);
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (bus.redirect_valid) begin
            pc_q     <= bus.redirect_pc;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                pc_q     <= pc_d;
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= bus.imem_data;
            epc_q[wr_ptr_q]   <= pc_q;
            fold_q[wr_ptr_q]  <= fold;
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.out_valid  = head_valid;
    assign bus.out_instr  = head_valid ? instr_q[rd_ptr_q] : '0;
    assign bus.out_pc     = head_valid ? epc_q[rd_ptr_q]   : '0;
    assign bus.out_folded = head_valid & fold_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked each
// cycle against a queue-based model; a second FOLD_J=0 instance checks sequential fetch.
module tb_instr_fetch;
    localparam int AW  = 10;
    localparam int DEP = 2;
    localparam logic [AW-1:0] RST_PC = '0;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] pc;
        logic          folded;
    } ent_t;

    logic clk = 1'b0;
    logic rst_r = 1'b1;
    logic rdy_r = 1'b0;
    logic rv_r  = 1'b0;
    logic [AW-1:0] rpc_r = '0;
    logic [31:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    bit            b_chk = 0;
    int            b_age = 0;
    int            b_next = 0;

    instr_fetch_if #(.ADDR_W(AW)) busa ();
    instr_fetch_if #(.ADDR_W(AW)) busb ();

    assign busa.imem_data      = mem[busa.imem_addr];
    assign busa.out_ready      = rdy_r;
    assign busa.redirect_valid = rv_r;
    assign busa.redirect_pc    = rpc_r;
    assign busb.imem_data      = mem[busb.imem_addr];
    assign busb.out_ready      = rdy_r;
    assign busb.redirect_valid = rv_r;
    assign busb.redirect_pc    = rpc_r;

    instr_fetch #(.ADDR_W(AW), .RESET_PC(0), .DEPTH(DEP), .FOLD_J(1)) dut_a (
        .clk(clk), .rst(rst_r), .bus(busa)
    );
    instr_fetch #(.ADDR_W(AW), .RESET_PC(0), .DEPTH(DEP), .FOLD_J(0)) dut_b (
        .clk(clk), .rst(rst_r), .bus(busb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Called at a falling edge: compare outputs with the model, apply the new
    // inputs, advance the model by the rules for the coming rising edge.
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] rpc);
        ent_t head;
        ent_t e;
        logic [31:0] w;
        bit do_pop, do_push;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("imem_addr", 32'(busa.imem_addr), 32'(m_pc));
        chk("out_valid", 32'(busa.out_valid), 32'(mq.size() > 0));
        chk("out_instr", busa.out_instr, head.instr);
        chk("out_pc", 32'(busa.out_pc), 32'(head.pc));
        chk("out_folded", 32'(busa.out_folded), 32'(head.folded));
        if (b_chk) begin
            chk("seq_valid", 32'(busb.out_valid), 32'(b_age > 0));
            if (b_age > 0) begin
                chk("seq_pc", 32'(busb.out_pc), 32'(b_next));
                chk("seq_instr", busb.out_instr, mem[b_next]);
                chk("seq_folded", 32'(busb.out_folded), 32'd0);
                b_next++;
            end
            b_age++;
        end
        rst_r = r; rdy_r = rdy; rv_r = rv; rpc_r = rpc;
        if (r) begin
            mq.delete();
            m_pc = RST_PC;
        end else if (rv) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = (mq.size() < DEP) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                w = mem[m_pc];
                e.instr  = w;
                e.pc     = m_pc;
                e.folded = (w[31:26] == 6'h28);
                mq.push_back(e);
                m_pc = e.folded ? w[AW-1:0] : AW'((int'(m_pc) + 1) % 1024);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    initial begin
        clear_mem();
        mem[0] = 32'h40210001;
        mem[1] = 32'hA0000000;
        rst_r = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();
        m_pc = RST_PC;

        // Two-instruction loop via J fold; B fetches straight through.
        step(1, 1, 0, '0);
        b_chk = 1; b_age = 0; b_next = 0;
        repeat (14) step(0, 1, 0, '0);
        b_chk = 0;

        // Stall with empty ROM, then drain back-to-back.
        clear_mem();
        step(1, 0, 0, '0);
        repeat (5) step(0, 0, 0, '0);
        repeat (6) step(0, 1, 0, '0);

        // Redirect to the top address; PC wraps to 0 after it.
        step(0, 1, 1, 10'h3FF);
        chk("redir_gap", 32'(busa.out_valid), 32'd0);
        step(0, 1, 0, '0);
        chk("redir_pc", 32'(busa.out_pc), 32'h3FF);
        repeat (4) step(0, 1, 0, '0);

        // Full FIFO (pc 4,5) with a same-cycle redirect: both entries lost.
        step(0, 0, 1, 10'h004);
        repeat (4) step(0, 0, 0, '0);
        step(0, 1, 1, 10'h020);
        step(0, 1, 0, '0);
        chk("flush_pc", 32'(busa.out_pc), 32'h020);
        repeat (3) step(0, 1, 0, '0);

        // Reset while full.
        repeat (4) step(0, 0, 0, '0);
        step(1, 1, 0, '0);
        repeat (5) step(0, 1, 0, '0);

        // Random program with frequent J words and random control.
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(3) == 0) mem[i] = {6'h28, 26'($urandom)};
            else mem[i] = $urandom;
        end
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)),
                 ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                 AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch front end for the Nova core. It owns the program counter and drives a word address into the combinational, word-addressed instruction ROM, capturing the returned word the same cycle. Fetched words are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. It accepts redirects from execute and can optionally fold unconditional J instructions (opcode 6'h28) at fetch, so a tight loop runs without bubbles.

Parameters:
ADDR_W, 10, width of the word address and PC.
RESET_PC, 0, word address loaded into the PC on reset.
DEPTH, 2, number of FIFO entries, each holding instr, pc and folded flag; must be 2 or more.
FOLD_J, 1, 1 = follow J targets at fetch; 0 = fetch strictly sequentially.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
imem_addr  out  ADDR_W  word address to instruction ROM; equals the PC register
imem_data  in  32  instruction word for imem_addr, valid the same cycle
out_valid  out  1  FIFO head holds an instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  32  head instruction word; 0 when out_valid=0
out_pc  out  ADDR_W  word address of the head instruction; 0 when out_valid=0
out_folded  out  1  head is a J already followed by fetch; execute must not redirect on it
redirect_valid  in  1  load the PC from redirect_pc and flush the FIFO
redirect_pc  in  ADDR_W  redirect target word address

Behaviour:
- Reset (rst=1 at a clk edge): PC<=RESET_PC; FIFO count<=0; out_valid=0; out_instr=0; out_pc=0; out_folded=0. rst takes priority over every other input.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & (count<DEPTH | pop).
- On push: the entry {imem_data, PC, fold} is written at the tail, and the PC advances.
- fold = FOLD_J & (imem_data[31:26]==6'h28).
- Next PC when fold=1: imem_data[ADDR_W-1:0] (low bits of imm26; upper bits ignored).
- Next PC when fold=0: PC+1, mod 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
- No push: the PC holds and imem_addr stays stable.
- Simultaneous push and pop: count is unchanged and the order is preserved. A full FIFO with pop accepts a push in the same cycle, giving no bubble at full throughput.
- Redirect (redirect_valid=1 at an edge): FIFO flushed (count<=0); PC<=redirect_pc; no push or pop that cycle, even if out_ready=1. The flushed entries are never presented.
- Redirect timing for a redirect at cycle N:
  - cycle N+1: imem_addr=redirect_pc, out_valid=0.
  - cycle N+2: out_valid=1 with out_pc=redirect_pc.
- Startup latency: first cycle after reset, imem_addr=RESET_PC and out_valid=0. Next cycle: out_valid=1, out_pc=RESET_PC.
- Steady state with out_ready held at 1: one instruction per cycle, and out_valid stays high.
- Head outputs come from registered FIFO storage; there is no combinational path from imem_data to out_*.
- out_ready may toggle arbitrarily. Head data must stay stable while out_valid=1 and out_ready=0.
- Invalid input: a J with fold=1 that targets its own PC loops legally; no special case.

Test Plan:
- Program mem {0:0x40210001, 1:0xA0000000, others 0}; release reset with out_ready=1 -> out_pc sequence 0,1,0,1,… with no gaps; out_folded=1 only at pc 1; out_instr alternates 0x40210001/0xA0000000.
- All-zero memory; out_ready=0 after reset -> count reaches 2 (pc 0,1 stored); imem_addr holds at 2; raise out_ready -> pc 0,1,2,3 emitted back-to-back.
- ADDR_W=10; redirect to 0x3FF at cycle N -> out_valid=0 in N+1; out_pc=0x3FF in N+2, then 0x000 (wrap).
- FIFO full (pc 4,5), out_ready=1, and redirect to 0x20 in the same cycle -> pc 4 never accepted; pc 5 never presented; next out_pc=0x20.
- rst pulsed mid-stream with FIFO full -> next cycle out_valid=0 and imem_addr=RESET_PC; stream restarts from RESET_PC.
- FOLD_J=0 with the first program -> out_pc 0,1,2,3,…; out_folded always 0.
